mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: lets NREQ requesters share one external multiplier.
// A round-robin pick in IDLE latches one requester's operands, a single start
// pulse launches the multiplier, the result (or a timeout abort) is held in
// RESP until the granted requester takes it.

module mult_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 4,
   parameter int PWIDTH  = 2 * WIDTH,
   parameter int TIMEOUT = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_x,
   input  logic [NREQ*WIDTH-1:0]   req_y,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         rsp_valid,
   input  logic [NREQ-1:0]         rsp_ready,
   output logic [PWIDTH-1:0]       rsp_product,
   output logic                    rsp_err,
   output logic [WIDTH-1:0]        mul_x,
   output logic [WIDTH-1:0]        mul_y,
   output logic                    mul_start,
   input  logic                    mul_ready,
   input  logic [PWIDTH-1:0]       mul_product,
   output logic                    busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     lastGrant_q, lastGrant_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PWIDTH-1:0] result_q, result_d;
   logic              err_q, err_d;

   logic [IW-1:0]     pick;
   logic              found;

   // Round-robin search: first valid requester starting just after the last one served
   always_comb begin
      logic [IW-1:0] idx;
      idx   = '0;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(lastGrant_q) + i) % NREQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   // Next-state and output decode; operand/result outputs are gated by state so they read 0 when idle
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      x_d         = x_q;
      y_d         = y_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      err_d       = err_q;
      req_ready   = '0;
      rsp_valid   = '0;
      mul_start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               req_ready[pick] = 1'b1;
               grant_d         = pick;
               x_d             = req_x[pick*WIDTH +: WIDTH];
               y_d             = req_y[pick*WIDTH +: WIDTH];
               state_d         = ISSUE;
            end
         end
         ISSUE: begin
            mul_start = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q != '0 && mul_ready) begin
               result_d = mul_product;
               err_d    = 1'b0;
               state_d  = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            rsp_valid[grant_q] = 1'b1;
            if (rsp_ready[grant_q]) begin
               lastGrant_d = grant_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst_in) begin
         req_ready = '0;
      end
   end

   assign busy        = (state_q != IDLE);
   assign mul_x       = (state_q == IDLE) ? '0 : x_q;
   assign mul_y       = (state_q == IDLE) ? '0 : y_q;
   assign rsp_product = (state_q == RESP) ? result_q : '0;
   assign rsp_err     = (state_q == RESP) ? err_q : 1'b0;

   // State registers; reset drops any in-flight operation and points last grant at NREQ-1
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         lastGrant_q <= IW'(NREQ - 1);
         x_q         <= '0;
         y_q         <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier and a
// response scoreboard filled as requests are driven.

module tb_mult_share_arbiter;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 4;
   localparam int PWIDTH  = 8;
   localparam int TIMEOUT = 16;

   typedef struct {
      int               idx;
      logic [PWIDTH-1:0] prod;
      logic             err;
   } rsp_t;

   logic                  clk_in = 1'b0;
   logic                  rst_in;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_x;
   logic [NREQ*WIDTH-1:0] req_y;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [NREQ-1:0]       rsp_ready;
   logic [PWIDTH-1:0]     rsp_product;
   logic                  rsp_err;
   logic [WIDTH-1:0]      mul_x;
   logic [WIDTH-1:0]      mul_y;
   logic                  mul_start;
   logic                  mul_ready;
   logic [PWIDTH-1:0]     mul_product;
   logic                  busy;

   int total = 0;
   int bad = 0;
   int lat = 0;
   int startCount = 0;
   int mulDelay = 1;
   logic mulHang = 1'b0;
   int mulCnt;
   logic [PWIDTH-1:0] mulHeld;
   logic [WIDTH-1:0] opX [NREQ];
   logic [WIDTH-1:0] opY [NREQ];
   rsp_t sb [$];

   mult_share_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .PWIDTH(PWIDTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mul_x(mul_x), .mul_y(mul_y), .mul_start(mul_start),
      .mul_ready(mul_ready), .mul_product(mul_product), .busy(busy)
   );

   // Free-running clock
   always #5 clk_in = ~clk_in;

   // Multiplier model: ready drops on start and rises mulDelay cycles later with x*y
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mul_ready   <= 1'b0;
         mul_product <= '0;
         mulHeld     <= '0;
         mulCnt      <= 0;
      end else if (mul_start) begin
         mulHeld <= {4'b0, mul_x} * {4'b0, mul_y};
         if (mulHang) begin
            mul_ready <= 1'b0;
            mulCnt    <= 0;
         end else if (mulDelay == 0) begin
            mul_ready   <= 1'b1;
            mul_product <= {4'b0, mul_x} * {4'b0, mul_y};
         end else begin
            mul_ready <= 1'b0;
            mulCnt    <= mulDelay;
         end
      end else if (mulCnt == 1) begin
         mul_ready   <= 1'b1;
         mul_product <= mulHeld;
         mulCnt      <= 0;
      end else if (mulCnt != 0) begin
         mulCnt <= mulCnt - 1;
      end
   end

   // Count start pulses seen on the multiplier interface
   always @(posedge clk_in) begin
      if (mul_start === 1'b1) startCount <= startCount + 1;
   end

   // Hard stop in case something wedges the sequence
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: normal result expected, 1: timeout abort expected, 2: no response expected
   task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input int mode);
      rsp_t e;
      opX[idx] = x;
      opY[idx] = y;
      req_x[idx*WIDTH +: WIDTH] = x;
      req_y[idx*WIDTH +: WIDTH] = y;
      req_valid[idx] = 1'b1;
      if (mode != 2) begin
         e.idx  = idx;
         e.prod = (mode == 1) ? 8'd0 : {4'b0, x} * {4'b0, y};
         e.err  = (mode == 1);
         sb.push_back(e);
      end
   endtask

   task automatic acceptOne(input int expIdx);
      int n;
      logic [NREQ-1:0] seen;
      n = 0;
      #1;
      while (req_ready === '0 && n < 40) begin
         step();
         n++;
      end
      seen = req_ready;
      checkOutput("grant", 64'(seen), 64'(1) << expIdx);
      step();
      lat = 1;
      checkOutput("issueStart", 64'(mul_start), 64'(1));
      checkOutput("issueMulX", 64'(mul_x), 64'(opX[expIdx]));
      checkOutput("issueMulY", 64'(mul_y), 64'(opY[expIdx]));
      checkOutput("issueBusy", 64'(busy), 64'(1));
      checkOutput("issueNoReady", 64'(req_ready), 64'(0));
      req_valid = req_valid & ~seen;
   endtask

   task automatic waitRsp(input int expLat);
      rsp_t e;
      while (rsp_valid === '0 && lat < 60) begin
         step();
         lat++;
      end
      if (expLat > 0) checkOutput("latency", 64'(lat), 64'(expLat));
      checkOutput("sbNotEmpty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checkOutput("rspValid", 64'(rsp_valid), 64'(1) << e.idx);
         checkOutput("rspProduct", 64'(rsp_product), 64'(e.prod));
         checkOutput("rspErr", 64'(rsp_err), 64'(e.err));
      end
   endtask

   task automatic finishRsp();
      step();
      checkOutput("postRspValid", 64'(rsp_valid), 64'(0));
      checkOutput("postRspProduct", 64'(rsp_product), 64'(0));
      checkOutput("postRspErr", 64'(rsp_err), 64'(0));
      checkOutput("postRspBusy", 64'(busy), 64'(0));
   endtask

   // Directed sequence
   initial begin
      int s0;
      int order [5];
      logic [NREQ-1:0] anyRsp;
      order = '{0, 1, 2, 3, 0};
      rst_in    = 1'b1;
      req_valid = '1;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = '1;
      for (int i = 0; i < NREQ; i++) begin
         opX[i] = '0;
         opY[i] = '0;
      end

      $display("[TB] reset state");
      step();
      step();
      checkOutput("rstReqReady", 64'(req_ready), 64'(0));
      checkOutput("rstRspValid", 64'(rsp_valid), 64'(0));
      checkOutput("rstBusy", 64'(busy), 64'(0));
      checkOutput("rstMulStart", 64'(mul_start), 64'(0));
      checkOutput("rstMulX", 64'(mul_x), 64'(0));
      checkOutput("rstProduct", 64'(rsp_product), 64'(0));
      req_valid = '0;
      rst_in    = 1'b0;
      step();

      $display("[TB] single request, slow multiplier");
      mulDelay = 4;
      s0 = startCount;
      applyStimulus(0, 4'd10, 4'd1, 0);
      acceptOne(0);
      waitRsp(7);
      finishRsp();
      checkOutput("singleStarts", 64'(startCount - s0), 64'(1));

      $display("[TB] minimum latency with stale ready masked");
      mulDelay = 0;
      applyStimulus(2, 4'd15, 4'd15, 0);
      acceptOne(2);
      waitRsp(4);
      finishRsp();

      $display("[TB] all four requesters after reset");
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      step();
      mulDelay = 1;
      s0 = startCount;
      applyStimulus(0, 4'd3, 4'd4, 0);
      applyStimulus(1, 4'd5, 4'd6, 0);
      applyStimulus(2, 4'd7, 4'd8, 0);
      applyStimulus(3, 4'd9, 4'd9, 0);
      for (int k = 0; k < 5; k++) begin
         acceptOne(order[k]);
         if (k == 0) applyStimulus(0, 4'd15, 4'd2, 0);
         waitRsp(4);
         finishRsp();
      end
      checkOutput("startsPerGrant", 64'(startCount - s0), 64'(5));

      $display("[TB] round robin wraps past last grant");
      applyStimulus(1, 4'd3, 4'd5, 0);
      acceptOne(1);
      waitRsp(4);
      finishRsp();
      applyStimulus(3, 4'd6, 4'd7, 0);
      applyStimulus(1, 4'd2, 4'd2, 0);
      acceptOne(3);
      waitRsp(4);
      finishRsp();
      acceptOne(1);
      waitRsp(4);
      finishRsp();

      $display("[TB] timeout then normal operation");
      mulHang = 1'b1;
      applyStimulus(2, 4'd7, 4'd9, 1);
      acceptOne(2);
      waitRsp(18);
      finishRsp();
      mulHang  = 1'b0;
      mulDelay = 2;
      applyStimulus(2, 4'd2, 4'd3, 0);
      acceptOne(2);
      waitRsp(5);
      finishRsp();

      $display("[TB] ready on the last wait cycle");
      mulDelay = 15;
      applyStimulus(1, 4'd11, 4'd13, 0);
      acceptOne(1);
      waitRsp(18);
      finishRsp();

      $display("[TB] reset during wait");
      mulDelay = 4;
      applyStimulus(2, 4'd5, 4'd5, 2);
      acceptOne(2);
      step();
      #2;
      rst_in = 1'b1;
      #1;
      checkOutput("asyncRstBusy", 64'(busy), 64'(0));
      checkOutput("asyncRstMulX", 64'(mul_x), 64'(0));
      checkOutput("asyncRstMulY", 64'(mul_y), 64'(0));
      checkOutput("asyncRstStart", 64'(mul_start), 64'(0));
      checkOutput("asyncRstRspValid", 64'(rsp_valid), 64'(0));
      step();
      step();
      rst_in = 1'b0;
      anyRsp = '0;
      for (int k = 0; k < 8; k++) begin
         step();
         anyRsp = anyRsp | rsp_valid | {NREQ{busy}};
      end
      checkOutput("noAbortedRsp", 64'(anyRsp), 64'(0));
      mulDelay = 1;
      applyStimulus(0, 4'd5, 4'd6, 0);
      applyStimulus(3, 4'd1, 4'd1, 0);
      acceptOne(0);
      waitRsp(4);
      finishRsp();
      acceptOne(3);
      waitRsp(4);
      finishRsp();

      $display("[TB] response stall with other rsp_ready bits high");
      rsp_ready = 4'b1101;
      applyStimulus(1, 4'd4, 4'd4, 0);
      acceptOne(1);
      applyStimulus(2, 4'd9, 4'd3, 0);
      waitRsp(4);
      for (int k = 0; k < 3; k++) begin
         step();
         checkOutput("stallRspValid", 64'(rsp_valid), 64'(4'b0010));
         checkOutput("stallProduct", 64'(rsp_product), 64'(16));
         checkOutput("stallErr", 64'(rsp_err), 64'(0));
         checkOutput("stallBusy", 64'(busy), 64'(1));
         checkOutput("stallNoReady", 64'(req_ready), 64'(0));
      end
      rsp_ready = '1;
      step();
      checkOutput("acceptAfterHs", 64'(req_ready), 64'(4'b0100));
      acceptOne(2);
      waitRsp(4);
      finishRsp();

      checkOutput("sbDrained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
